// File: rtl/fscale2n_pkg.sv
// Shared vector-engine definitions for the power-of-two FP scaler:
// default field widths, per-lane flag bit positions, lane classes and
// exponent bias helpers.
`ifndef FSCALE2N_PKG_SV
`define FSCALE2N_PKG_SV

package fscale2n_pkg;

    // Default FP format (bf16) and engine geometry
    localparam int DEF_I_EXP = 8;
    localparam int DEF_I_MNT = 7;
    localparam int DEF_LANES = 4;
    localparam int DEF_SHW   = 8;

    // Per-lane flag layout inside out_flag
    localparam int FLAG_W  = 2;
    localparam int FLAG_UF = 0;  // nonzero input flushed to zero
    localparam int FLAG_OF = 1;  // finite input saturated to infinity

    // Operand class decided in S1, consumed by the S2 pack logic
    typedef enum logic [1:0] {
        CLS_NORM = 2'd0,
        CLS_SUB  = 2'd1,
        CLS_ZERO = 2'd2,
        CLS_SPEC = 2'd3
    } lane_cls_e;

    // Exponent bias for an exp_w-bit exponent field
    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // All-ones exponent code (inf/NaN) for an exp_w-bit field
    function automatic int fp_exp_max(input int exp_w);
        return (1 << exp_w) - 1;
    endfunction

endpackage

`endif

// File: rtl/fscale2n_lane.sv
// One FP lane of the x*2^k scaler, purely combinational. The S1 half
// classifies the operand, normalises subnormals and forms the biased
// exponent sum; the S2 half works from the registered S1 results and
// produces the packed result and the underflow/overflow flags.
module fscale2n_lane
    import fscale2n_pkg::*;
#(
    parameter  int I_EXP  = DEF_I_EXP,
    parameter  int I_MNT  = DEF_I_MNT,
    parameter  int SHW    = DEF_SHW,
    localparam int I_DATA = I_EXP + I_MNT + 1,
    localparam int W_E    = I_EXP + SHW + 1
) (
    input  logic [I_DATA-1:0]     i_s1_x,
    input  logic [SHW-1:0]        i_s1_k,
    output logic [I_DATA-1:0]     o_s1_x,
    output lane_cls_e             o_s1_cls,
    output logic signed [W_E-1:0] o_s1_esum,
    output logic [I_MNT-1:0]      o_s1_mnt,
    input  logic [I_DATA-1:0]     i_s2_x,
    input  lane_cls_e             i_s2_cls,
    input  logic signed [W_E-1:0] i_s2_esum,
    input  logic [I_MNT-1:0]      i_s2_mnt,
    output logic [I_DATA-1:0]     o_s2_res,
    output logic [FLAG_W-1:0]     o_s2_flag
);

    localparam int                    LZW      = $clog2(I_MNT + 1);
    localparam logic [I_EXP-1:0]      EXP_ONES = '1;
    localparam logic signed [W_E-1:0] ESUM_OVF = W_E'(fp_exp_max(I_EXP));
    localparam logic signed [W_E-1:0] ESUM_ONE = W_E'(1);
    localparam logic signed [W_E-1:0] SH_ZERO  = W_E'(I_MNT + 1);

    // ---------------- S1: decode, leading-zero count, exponent sum -------
    logic [I_EXP-1:0]      w_e;
    logic [I_MNT-1:0]      w_m;
    logic [LZW-1:0]        w_lz;
    logic signed [W_E-1:0] w_e_eff;
    logic signed [W_E-1:0] w_k_ext;

    assign w_e     = i_s1_x[I_DATA-2 -: I_EXP];
    assign w_m     = i_s1_x[I_MNT-1:0];
    assign w_k_ext = {{(W_E-SHW){i_s1_k[SHW-1]}}, i_s1_k};
    assign o_s1_x  = i_s1_x;

    // Leading-zero count of the mantissa field (highest set bit wins)
    always_comb begin
        w_lz = '0;
        for (int i = 0; i < I_MNT; i++) begin
            if (w_m[i]) w_lz = LZW'(I_MNT - 1 - i);
        end
    end

    // Classify; a subnormal gets its leading one moved to the hidden bit
    // and an effective exponent of -lz so it behaves like a normal value
    always_comb begin
        o_s1_cls = CLS_NORM;
        w_e_eff  = $signed({{(W_E-I_EXP){1'b0}}, w_e});
        o_s1_mnt = w_m;
        if (w_e == EXP_ONES) begin
            o_s1_cls = CLS_SPEC;
        end else if (w_e == '0) begin
            if (w_m == '0) begin
                o_s1_cls = CLS_ZERO;
            end else begin
                o_s1_cls = CLS_SUB;
                w_e_eff  = -$signed({{(W_E-LZW){1'b0}}, w_lz});
                o_s1_mnt = w_m << (w_lz + LZW'(1));
            end
        end
    end

    assign o_s1_esum = w_e_eff + w_k_ext;

    // ---------------- S2: denormalising shift and pack -------------------
    logic                  w_s2_sign;
    logic signed [W_E-1:0] w_sh;
    logic [I_MNT-1:0]      w_den;

    assign w_s2_sign = i_s2_x[I_DATA-1];
    assign w_sh      = ESUM_ONE - i_s2_esum;
    // Only meaningful when 1 <= w_sh <= I_MNT, which fits in LZW bits
    assign w_den     = I_MNT'({1'b1, i_s2_mnt} >> w_sh[LZW-1:0]);

    // Select overflow, normal, subnormal or flush-to-zero; specials and
    // zeros pass through untouched
    always_comb begin
        o_s2_res  = i_s2_x;
        o_s2_flag = '0;
        if (i_s2_cls == CLS_NORM || i_s2_cls == CLS_SUB) begin
            if (i_s2_esum >= ESUM_OVF) begin
                o_s2_res           = {w_s2_sign, EXP_ONES, {I_MNT{1'b0}}};
                o_s2_flag[FLAG_OF] = 1'b1;
            end else if (i_s2_esum >= ESUM_ONE) begin
                o_s2_res = {w_s2_sign, i_s2_esum[I_EXP-1:0], i_s2_mnt};
            end else if (w_sh >= SH_ZERO) begin
                o_s2_res           = {w_s2_sign, {(I_DATA-1){1'b0}}};
                o_s2_flag[FLAG_UF] = 1'b1;
            end else begin
                o_s2_res = {w_s2_sign, {I_EXP{1'b0}}, w_den};
            end
        end
    end

endmodule

// File: rtl/fscale2n.sv
// Multi-lane FP power-of-two scaler: out = in * 2^in_shift per lane.
// Two-stage pipeline (S1 decode/exponent sum, S2 shift/pack) with a
// valid/ready handshake on each side.
//
// Handshake: a beat moves across a port on a rising edge where valid and
// ready are both high. A producer holding valid keeps its data stable
// until accepted; out_valid/out_data/out_flag hold while out_ready is low.
// in_ready depends only on registered state and out_ready.
module fscale2n
    import fscale2n_pkg::*;
#(
    parameter  int I_EXP  = DEF_I_EXP,
    parameter  int I_MNT  = DEF_I_MNT,
    parameter  int LANES  = DEF_LANES,
    parameter  int SHW    = DEF_SHW,
    localparam int I_DATA = I_EXP + I_MNT + 1
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*I_DATA-1:0]   in_data,
    input  logic [SHW-1:0]            in_shift,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*I_DATA-1:0]   out_data,
    output logic [LANES*FLAG_W-1:0]   out_flag
);

    localparam int W_E = I_EXP + SHW + 1;

    logic r_s1_valid;
    logic r_s2_valid;

    logic [LANES*I_DATA-1:0] r_s1_x;
    lane_cls_e               r_s1_cls  [LANES];
    logic signed [W_E-1:0]   r_s1_esum [LANES];
    logic [I_MNT-1:0]        r_s1_mnt  [LANES];

    logic [LANES*I_DATA-1:0] r_out_data;
    logic [LANES*FLAG_W-1:0] r_out_flag;

    logic [LANES*I_DATA-1:0] w_s1_x;
    lane_cls_e               w_s1_cls  [LANES];
    logic signed [W_E-1:0]   w_s1_esum [LANES];
    logic [I_MNT-1:0]        w_s1_mnt  [LANES];
    logic [LANES*I_DATA-1:0] w_s2_res;
    logic [LANES*FLAG_W-1:0] w_s2_flag;

    logic w_s2_en;
    logic w_s1_load;
    logic w_s2_load;

    // S2 can take a new beat when empty or when its beat leaves this edge;
    // S1 can take a beat when empty or when its beat moves into S2
    assign w_s2_en   = !r_s2_valid || out_ready;
    assign in_ready  = !r_s1_valid || !r_s2_valid || out_ready;
    assign w_s1_load = in_valid && in_ready;
    assign w_s2_load = w_s2_en && r_s1_valid;

    assign out_valid = r_s2_valid;
    assign out_data  = r_out_data;
    assign out_flag  = r_out_flag;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        fscale2n_lane #(
            .I_EXP (I_EXP),
            .I_MNT (I_MNT),
            .SHW   (SHW)
        ) u_lane (
            .i_s1_x    (in_data[l*I_DATA +: I_DATA]),
            .i_s1_k    (in_shift),
            .o_s1_x    (w_s1_x[l*I_DATA +: I_DATA]),
            .o_s1_cls  (w_s1_cls[l]),
            .o_s1_esum (w_s1_esum[l]),
            .o_s1_mnt  (w_s1_mnt[l]),
            .i_s2_x    (r_s1_x[l*I_DATA +: I_DATA]),
            .i_s2_cls  (r_s1_cls[l]),
            .i_s2_esum (r_s1_esum[l]),
            .i_s2_mnt  (r_s1_mnt[l]),
            .o_s2_res  (w_s2_res[l*I_DATA +: I_DATA]),
            .o_s2_flag (w_s2_flag[l*FLAG_W +: FLAG_W])
        );
    end

    // Stage occupancy: S1 fills on accept and drains into S2; S2 drains out
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            if (w_s1_load) begin
                r_s1_valid <= 1'b1;
            end else if (w_s2_en) begin
                r_s1_valid <= 1'b0;
            end
            if (w_s2_en) begin
                r_s2_valid <= r_s1_valid;
            end
        end
    end

    // S1 register: decoded operands of the accepted beat
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_x <= '0;
            for (int l = 0; l < LANES; l++) begin
                r_s1_cls[l]  <= CLS_NORM;
                r_s1_esum[l] <= '0;
                r_s1_mnt[l]  <= '0;
            end
        end else if (w_s1_load) begin
            r_s1_x <= w_s1_x;
            for (int l = 0; l < LANES; l++) begin
                r_s1_cls[l]  <= w_s1_cls[l];
                r_s1_esum[l] <= w_s1_esum[l];
                r_s1_mnt[l]  <= w_s1_mnt[l];
            end
        end
    end

    // S2 register: packed results, held while the consumer stalls
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out_data <= '0;
            r_out_flag <= '0;
        end else if (w_s2_load) begin
            r_out_data <= w_s2_res;
            r_out_flag <= w_s2_flag;
        end
    end

endmodule

// File: tb/tb_fscale2n.sv
// Bench for fscale2n at bf16 defaults: directed spec vectors, a random
// stalled stream against a value-level reference model, and mid-flight reset.
module tb_fscale2n;

    localparam int LANES  = 4;
    localparam int DW     = 16;
    localparam int DATA_W = LANES * DW;
    localparam int FLG_W  = LANES * 2;
    localparam int W      = DATA_W + FLG_W;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic [7:0]        in_shift = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [FLG_W-1:0]  out_flag;

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_q[$];

    fscale2n dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shift  (in_shift),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flag  (out_flag)
    );

    // ---------------- clock ----------------------------------------------
    always #5 clk = ~clk;

    // ---------------- checker --------------------------------------------
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ------------------------------------
    // Value = M * 2^E exactly; rescale by 2^k and re-encode as bf16 with
    // truncation toward zero. Result is {flags[1:0], bits[15:0]}.
    function automatic logic [17:0] ref_lane(input logic [15:0] x, input int k);
        int  e, m, mm, ee, p, eb, t, mant, field;
        logic s;
        s = x[15];
        e = int'(x[14:7]);
        m = int'(x[6:0]);
        if (e == 255) return {2'b00, x};
        if (e == 0 && m == 0) return {2'b00, x};
        mm = (e == 0) ? m : (128 + m);
        ee = ((e == 0) ? 1 : e) - 127 - 7;
        p = 0;
        for (int i = 0; i < 8; i++) if (((mm >> i) & 1) != 0) p = i;
        eb = p + ee + k + 127;
        if (eb >= 255) return {2'b10, s, 8'hFF, 7'h00};
        if (eb >= 1) begin
            mant = (mm << (7 - p)) & 127;
            return {2'b00, s, eb[7:0], mant[6:0]};
        end
        t = eb - p + 6;
        field = (t >= 0) ? (mm << t) : (mm >> (-t));
        if (field == 0) return {2'b01, s, 15'h0000};
        return {2'b00, s, 8'h00, field[6:0]};
    endfunction

    function automatic logic [W-1:0] ref_beat(input logic [DATA_W-1:0] d, input logic [7:0] kb);
        logic [DATA_W-1:0] rd;
        logic [FLG_W-1:0]  rf;
        logic [17:0]       lr;
        int k;
        k = int'($signed(kb));
        for (int l = 0; l < LANES; l++) begin
            lr = ref_lane(d[l*DW +: DW], k);
            rd[l*DW +: DW] = lr[15:0];
            rf[l*2 +: 2]   = lr[17:16];
        end
        return {rf, rd};
    endfunction

    // ---------------- stimulus helpers -----------------------------------
    function automatic logic [15:0] rand_lane();
        logic [15:0] v;
        v = 16'($urandom);
        case ($urandom_range(0, 5))
            0: v[14:7] = 8'($urandom_range(1, 254));
            1: v[14:7] = 8'h00;
            2: v[14:0] = '0;
            3: v[14:7] = 8'hFF;
            4: v[14:7] = 8'($urandom_range(1, 4));
            default: v[14:7] = 8'($urandom_range(248, 254));
        endcase
        return v;
    endfunction

    function automatic logic [7:0] rand_k();
        if ($urandom_range(0, 3) == 0) return 8'($urandom);
        return 8'($urandom_range(0, 20) - 10);
    endfunction

    // ---------------- driver tasks ---------------------------------------
    // Single beat through an empty pipe with out_ready high
    task automatic run_beat(input string tag, input logic [DATA_W-1:0] d, input logic [7:0] k,
                            input logic [DATA_W-1:0] ed, input logic [FLG_W-1:0] ef);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = d;
        in_shift  = k;
        #1 check({tag, "_rdy"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_lat1"}, out_valid, 0);
        @(negedge clk);
        check({tag, "_vld"}, out_valid, 1);
        check({tag, "_data"}, out_data, ed);
        check({tag, "_flag"}, out_flag, ef);
        check({tag, "_model"}, {out_flag, out_data}, ref_beat(d, k));
    endtask

    // Random stream with random input gaps and output stalls
    task automatic run_stream(input int n_beats);
        int sent = 0;
        int cyc  = 0;
        logic acc = 1'b0;
        logic [W-1:0] e;
        in_valid = 1'b0;
        while ((sent < n_beats || exp_q.size() != 0 || in_valid) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (acc) begin
                in_valid = 1'b0;
                acc = 1'b0;
            end
            if (!in_valid && sent < n_beats && $urandom_range(0, 3) != 0) begin
                for (int l = 0; l < LANES; l++) in_data[l*DW +: DW] = rand_lane();
                in_shift = rand_k();
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("stream_extra", 1, 0);
                end else begin
                    e = exp_q[0];
                    check("stream_data", out_data, e[DATA_W-1:0]);
                    check("stream_flag", out_flag, e[W-1:DATA_W]);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_beat(in_data, in_shift));
                sent++;
                acc = 1'b1;
            end
        end
        check("stream_sent", sent, n_beats);
        check("stream_drain", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
        check("stream_idle", out_valid, 0);
    endtask

    // Two beats in flight, then an asynchronous reset
    task automatic run_reset_midflight();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = {16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80};
        in_shift  = 8'h01;
        @(negedge clk);
        in_data   = {16'h4000, 16'h4000, 16'h4000, 16'h4000};
        @(negedge clk);
        in_valid  = 1'b0;
        check("rst_pre_vld", out_valid, 1);
        #2 rstn = 1'b0;
        #1;
        check("rst_vld", out_valid, 0);
        check("rst_rdy", in_ready, 1);
        check("rst_data", out_data, 0);
        check("rst_flag", out_flag, 0);
        @(negedge clk);
        check("rst_hold_vld", out_valid, 0);
        rstn = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_no_stale", out_valid, 0);
        end
    endtask

    // ---------------- main sequence and report ---------------------------
    initial begin
        repeat (2) @(negedge clk);
        check("reset_valid", out_valid, 0);
        check("reset_ready", in_ready, 1);
        check("reset_data", out_data, 0);
        check("reset_flag", out_flag, 0);
        rstn = 1'b1;

        run_beat("k_m1", {16'h0040, 16'h8001, 16'h0080, 16'h3F80}, 8'hFF,
                 {16'h0020, 16'h8000, 16'h0040, 16'h3F00}, {2'b00, 2'b01, 2'b00, 2'b00});
        run_beat("k_p2", {16'h8000, 16'hFF80, 16'h7FC1, 16'h7F00}, 8'h02,
                 {16'h8000, 16'hFF80, 16'h7FC1, 16'h7F80}, {2'b00, 2'b00, 2'b00, 2'b10});
        run_beat("k_m127", {16'h4000, 16'hBF80, 16'h0080, 16'h3F80}, 8'h81,
                 {16'h0080, 16'h8040, 16'h0000, 16'h0040}, {2'b00, 2'b00, 2'b01, 2'b00});
        run_beat("k_m16", {16'h0000, 16'h7FFF, 16'h4180, 16'h0080}, 8'hF0,
                 {16'h0000, 16'h7FFF, 16'h3980, 16'h0000}, {2'b00, 2'b00, 2'b00, 2'b01});
        run_beat("k_p8", {16'h3F80, 16'h007F, 16'h8001, 16'h0001}, 8'h08,
                 {16'h4380, 16'h047E, 16'h8100, 16'h0100}, {2'b00, 2'b00, 2'b00, 2'b00});
        run_beat("k_p127", {16'h0001, 16'hC000, 16'h4000, 16'h3F80}, 8'h7F,
                 {16'h3C80, 16'hFF80, 16'h7F80, 16'h7F00}, {2'b00, 2'b10, 2'b10, 2'b00});
        run_beat("k_m128", {16'h7F80, 16'h0000, 16'h3F80, 16'h7F7F}, 8'h80,
                 {16'h7F80, 16'h0000, 16'h0020, 16'h3F7F}, {2'b00, 2'b00, 2'b00, 2'b00});

        run_stream(40);

        run_reset_midflight();
        run_beat("post_rst", {16'h8000, 16'hFF80, 16'h7FC1, 16'h7F00}, 8'h02,
                 {16'h8000, 16'hFF80, 16'h7FC1, 16'h7F80}, {2'b00, 2'b00, 2'b00, 2'b10});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fscale2n.md
FSCALE2N -- requirements
Module: fscale2n

Interface
REQ-001 SHALL have parameter I_EXP, default 8, exponent field width.
REQ-002 SHALL have parameter I_MNT, default 7, mantissa field width.
REQ-003 SHALL have parameter LANES, default 4, number of parallel FP lanes.
REQ-004 SHALL have parameter SHW, default 8, width of the two's-complement scale exponent.
REQ-005 SHALL derive I_DATA = I_EXP+I_MNT+1, not overridable by the user.
REQ-006 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-007 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port in_valid  input  1  input beat valid.
REQ-009 SHALL have port in_ready  output  1  block accepts a beat this cycle.
REQ-010 SHALL have port in_data  input  LANES*I_DATA  packed operands, lane 0 in the LSBs.
REQ-011 SHALL have port in_shift  input  SHW  signed k, shared by all lanes; result = x*2^k.
REQ-012 SHALL have port out_valid  output  1  output beat valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts the beat.
REQ-014 SHALL have port out_data  output  LANES*I_DATA  scaled results.
REQ-015 SHALL have port out_flag  output  LANES*2  per lane: bit0 = underflow (nonzero input went to zero), bit1 = overflow (finite input went to inf).

Function
REQ-016 SHALL transfer a beat when valid&&ready on the same edge; no beat is dropped or duplicated.
REQ-017 SHALL be a 2-stage pipeline (S1: decode, exponent sum, leading-zero count; S2: shift, pack); latency is exactly 2 cycles with out_ready held high; throughput is 1 beat per cycle.
REQ-018 SHALL drive in_ready = !s1_valid || !s2_valid || out_ready, as a function of registered state and out_ready only, with no path from in_valid.
REQ-019 SHALL hold out_data, out_flag and out_valid stable while out_valid && !out_ready.
REQ-020 SHALL compute the biased exponent sum e' = e + k in I_EXP+SHW+1 signed bits, with no intermediate wrap-around.
REQ-021 SHALL pass exp all-ones inputs (inf, NaN) through bit-exact with flags 0.
REQ-022 SHALL return ±0 unchanged with flags 0.
REQ-023 SHALL, for normal x with 1 <= e' <= 2^I_EXP-2, output {s, e', m}.
REQ-024 SHALL, when e' >= 2^I_EXP-1, output {s, all-ones, 0} and set overflow.
REQ-025 SHALL, when e' <= 0, output the subnormal {s, 0, ({1,m} >> (1-e'))[I_MNT-1:0]}, truncated toward zero.
REQ-026 SHALL output {s, 0, 0} when the denormalising shift reaches I_MNT+1 or more, and set underflow.
REQ-027 SHALL treat a subnormal input (e=0, m!=0) as normalised by its leading-zero count before applying k; results follow REQ-023..026.
REQ-028 SHALL reproduce divide-by-2 behaviour for k = -1, including the e = 1 to subnormal case {s, 0, {1, m[I_MNT-1:1]}}.
REQ-029 SHALL process lanes independently; flags of one lane never affect another lane.

Reset
REQ-030 SHALL, while rstn = 0, clear s1_valid, s2_valid and out_valid to 0, clear all data/flag registers to 0, and drive in_ready = 1.
REQ-031 SHALL discard in-flight beats when reset is asserted mid-operation; the first beat after release appears 2 cycles after acceptance.

Structure
REQ-032 SHALL keep the FP field-width defaults, flag bit positions and bias helper constants in the shared vector-engine header, guarded by an include guard.
REQ-033 SHALL instantiate LANES copies of one combinational sub-module fscale2n_lane (classify, leading-zero count, exponent sum, shift/pack) split at the S1/S2 register boundary; the handshake lives only in fscale2n.

Verification (bf16 defaults)
REQ-034 SHALL pass: 0x3F80 with k = -1, then 0x0080 with k = -1 -> 0x3F00, then 0x0040, flags 0, latency 2.
REQ-035 SHALL pass: 0x7F00 with k = +2 -> 0x7F80, overflow = 1; 0x7FC1 with any k -> 0x7FC1, flags 0.
REQ-036 SHALL pass: 0x3F80 with k = -127 -> 0x0040; 0x0080 with k = -16 -> 0x0000, underflow = 1.
REQ-037 SHALL pass: subnormal 0x0001 with k = +8 -> 0x0100, flags 0.
REQ-038 SHALL pass: a back-to-back stream of 20 beats with out_ready toggled randomly -> output order and values match a reference model, no loss, and outputs stable while stalled.
REQ-039 SHALL pass: rstn pulsed low with 2 beats in flight -> out_valid = 0 next cycle, and no stale beat is emitted after release.
